// File: rtl/dbus_pkg.sv
// Shared definitions for the CPU data-bus responder: MMIO register map,
// STATUS field layout and the address-region classification.
package dbus_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'hFFFF_0000;

  // Byte offsets of the MMIO registers inside the 16-byte window
  localparam logic [3:0] OFF_CONSOLE = 4'h0;
  localparam logic [3:0] OFF_MTIME   = 4'h4;
  localparam logic [3:0] OFF_STATUS  = 4'h8;
  localparam logic [3:0] OFF_RSVD    = 4'hC;

  // STATUS register field positions
  localparam int unsigned COUNT_LSB = 0;
  localparam int unsigned COUNT_W   = 5;
  localparam int unsigned FULL_BIT  = 5;
  localparam int unsigned EMPTY_BIT = 6;
  localparam int unsigned OVF_BIT   = 8;

  typedef enum logic [1:0] {
    REG_CONSOLE = OFF_CONSOLE[3:2],
    REG_MTIME   = OFF_MTIME[3:2],
    REG_STATUS  = OFF_STATUS[3:2],
    REG_RSVD    = OFF_RSVD[3:2]
  } mmio_reg_e;

  typedef enum logic [1:0] {
    RGN_NONE,
    RGN_RAM,
    RGN_MMIO
  } region_e;

  // Word select within the MMIO window; byte offset bits [1:0] never matter
  function automatic mmio_reg_e reg_sel(input logic [31:0] addr);
    return mmio_reg_e'(addr[3:2]);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full is accepted only
// when a pop frees the head slot in the same cycle.
module sync_fifo #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en;
  logic             rd_en;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem[rd_ptr_q];

  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; emptiness is tracked by count and pointers alone.
  always_ff @(posedge clk) begin
    if (wr_en && !reset) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/dbus_responder.sv
// Responder end of the single-cycle CPU data bus: byte-lane RAM, console FIFO,
// cycle timer and a registered error pulse for illegal writes.
module dbus_responder
  import dbus_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 4096,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        bus_err
);

  localparam int unsigned IDX_W     = $clog2(RAM_WORDS);
  localparam int unsigned CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]      mem [RAM_WORDS];
  logic [IDX_W-1:0] ram_idx;
  region_e          region;
  mmio_reg_e        sel;

  logic [31:0]      mtime_q, mtime_d;
  logic             ovf_q, ovf_d;
  logic             bus_err_q, bus_err_d;

  logic             console_push;
  logic             mtime_load;
  logic             mtime_partial;
  logic             ovf_clear;
  logic             fifo_pop;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic [31:0]      status;

  // Decode
  always_comb begin
    region = RGN_NONE;
    if (daddr < RAM_BYTES)                      region = RGN_RAM;
    else if (daddr[31:4] == MMIO_BASE[31:4])    region = RGN_MMIO;
  end

  assign ram_idx = daddr[IDX_W+1:2];
  assign sel     = reg_sel(daddr);

  assign console_push  = !reset && (region == RGN_MMIO) && (sel == REG_CONSOLE) && dwe[0];
  assign mtime_load    = !reset && (region == RGN_MMIO) && (sel == REG_MTIME) && (dwe == 4'b1111);
  assign mtime_partial = (region == RGN_MMIO) && (sel == REG_MTIME) && (dwe != 4'b0000)
                         && (dwe != 4'b1111);
  assign ovf_clear     = !reset && (region == RGN_MMIO) && (sel == REG_STATUS) && dwe[1]
                         && dwdata[OVF_BIT];

  // RAM: each enabled lane commits on the edge; contents survive reset
  always_ff @(posedge clk) begin
    if (!reset && region == RGN_RAM) begin
      for (int i = 0; i < 4; i++) begin
        if (dwe[i]) mem[ram_idx][8*i +: 8] <= dwdata[8*i +: 8];
      end
    end
  end

  // Console FIFO
  assign fifo_pop = tx_valid && tx_ready;
  assign tx_valid = !fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_console_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (console_push),
    .din   (dwdata[7:0]),
    .pop   (fifo_pop),
    .dout  (tx_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state: a fresh overflow event wins over a same-cycle clear
  always_comb begin
    mtime_d   = mtime_load ? dwdata : mtime_q + 32'd1;
    ovf_d     = ovf_q;
    if (ovf_clear) ovf_d = 1'b0;
    if (console_push && fifo_full && !fifo_pop) ovf_d = 1'b1;
    bus_err_d = ((region == RGN_NONE) && (dwe != 4'b0000)) || mtime_partial;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mtime_q   <= '0;
      ovf_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      mtime_q   <= mtime_d;
      ovf_q     <= ovf_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;

  // Read path
  always_comb begin
    status                           = '0;
    status[COUNT_LSB +: COUNT_W]     = COUNT_W'(fifo_count);
    status[FULL_BIT]                 = fifo_full;
    status[EMPTY_BIT]                = fifo_empty;
    status[OVF_BIT]                  = ovf_q;
  end

  always_comb begin
    drdata = '0;
    unique case (region)
      RGN_RAM: drdata = mem[ram_idx];
      RGN_MMIO: begin
        unique case (sel)
          REG_CONSOLE: drdata = {24'b0, tx_data};
          REG_MTIME:   drdata = mtime_q;
          REG_STATUS:  drdata = status;
          default:     drdata = '0;
        endcase
      end
      default: drdata = '0;
    endcase
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Directed bench for dbus_responder: one-cycle vector table plus hand-written
// sequences for FIFO drain/overflow, MTIME load/wrap and reset mid-transfer.
module tb_dbus_responder;

  localparam logic [31:0] A_CONSOLE = 32'hFFFF_0000;
  localparam logic [31:0] A_MTIME   = 32'hFFFF_0004;
  localparam logic [31:0] A_STATUS  = 32'hFFFF_0008;
  localparam logic [31:0] A_RSVD    = 32'hFFFF_000C;

  logic        clk;
  logic        reset;
  logic [31:0] daddr;
  logic [31:0] dwdata;
  logic [3:0]  dwe;
  logic [31:0] drdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        bus_err;

  int n_vec;
  int n_err;

  dbus_responder dut (
    .clk      (clk),
    .reset    (reset),
    .daddr    (daddr),
    .dwdata   (dwdata),
    .dwe      (dwe),
    .drdata   (drdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .bus_err  (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        rdy;
    logic [31:0] raddr;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_txv;
    string       name;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive, take the edge, return to idle 1 ns after it
  task automatic cycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we,
                       input logic rdy);
    daddr    = a;
    dwdata   = d;
    dwe      = we;
    tx_ready = rdy;
    @(posedge clk);
    #1;
    dwe      = 4'b0000;
    tx_ready = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] a, input logic [31:0] exp);
    daddr = a;
    #1;
    check(name, drdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_vec    = 0;
    n_err    = 0;
    reset    = 1'b1;
    daddr    = '0;
    dwdata   = '0;
    dwe      = '0;
    tx_ready = 1'b0;

    //          waddr         wdata          we       rdy   raddr         exp_rd         err   txv   name
    vecs[0]  = '{32'h0,        32'h0,         4'b0000, 1'b0, A_STATUS,     32'h0000_0040, 1'b0, 1'b0, "status_rst"};
    vecs[1]  = '{32'h100,      32'hAABB_CCDD, 4'b1111, 1'b0, 32'h100,      32'hAABB_CCDD, 1'b0, 1'b0, "ram_full"};
    vecs[2]  = '{32'h100,      32'h00EE_0000, 4'b0100, 1'b0, 32'h100,      32'hAAEE_CCDD, 1'b0, 1'b0, "ram_lane2"};
    vecs[3]  = '{32'h8000_0000, 32'h1234_5678, 4'b1111, 1'b0, 32'h8000_0000, 32'h0,        1'b1, 1'b0, "unmap_wr"};
    vecs[4]  = '{32'h8000_0000, 32'h0,        4'b0000, 1'b0, 32'h100,      32'hAAEE_CCDD, 1'b0, 1'b0, "unmap_rd"};
    vecs[5]  = '{32'h0,        32'h1111_1111, 4'b1111, 1'b0, 32'h0,        32'h1111_1111, 1'b0, 1'b0, "ram_low"};
    vecs[6]  = '{32'h4000,     32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0,        32'h1111_1111, 1'b1, 1'b0, "ram_past_end"};
    vecs[7]  = '{32'h3FFC,     32'hCAFE_F00D, 4'b1111, 1'b0, 32'h3FFC,     32'hCAFE_F00D, 1'b0, 1'b0, "ram_top"};
    vecs[8]  = '{32'h4000,     32'h0,         4'b0000, 1'b0, 32'h4000,     32'h0,         1'b0, 1'b0, "past_end_rd"};
    vecs[9]  = '{A_RSVD,       32'h0000_0001, 4'b1111, 1'b0, A_RSVD,       32'h0,         1'b0, 1'b0, "rsvd_wr"};
    vecs[10] = '{A_CONSOLE,    32'h0000_0041, 4'b0001, 1'b0, A_STATUS,     32'h0000_0001, 1'b0, 1'b1, "push41"};
    vecs[11] = '{A_CONSOLE,    32'h0000_0042, 4'b0001, 1'b0, A_CONSOLE,    32'h0000_0041, 1'b0, 1'b1, "push42"};
    vecs[12] = '{A_CONSOLE,    32'h0000_0043, 4'b1111, 1'b0, A_STATUS,     32'h0000_0003, 1'b0, 1'b1, "push43"};
    vecs[13] = '{A_CONSOLE,    32'h0000_5500, 4'b0010, 1'b0, A_STATUS,     32'h0000_0003, 1'b0, 1'b1, "no_push_lane1"};
    vecs[14] = '{32'h0,        32'h0,         4'b0000, 1'b0, 32'h103,      32'hAAEE_CCDD, 1'b0, 1'b1, "ram_unaligned"};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int i = 0; i < 15; i++) begin
      cycle(vecs[i].waddr, vecs[i].wdata, vecs[i].we, vecs[i].rdy);
      rd_check({vecs[i].name, "/rd"}, vecs[i].raddr, vecs[i].exp_rd);
      check({vecs[i].name, "/err"}, {31'b0, bus_err}, {31'b0, vecs[i].exp_err});
      check({vecs[i].name, "/txv"}, {31'b0, tx_valid}, {31'b0, vecs[i].exp_txv});
    end

    // Drain 0x41,0x42,0x43 in order
    for (int i = 0; i < 3; i++) begin
      check("drain/txv", {31'b0, tx_valid}, 32'd1);
      check("drain/data", {24'b0, tx_data}, 32'h41 + 32'(i));
      cycle(32'h0, 32'h0, 4'b0000, 1'b1);
    end
    check("drain/txv_end", {31'b0, tx_valid}, 32'd0);
    rd_check("drain/status", A_STATUS, 32'h0000_0040);

    // Overflow: nine pushes into an eight-entry FIFO
    for (int i = 0; i < 9; i++) cycle(A_CONSOLE, 32'h60 + 32'(i), 4'b0001, 1'b0);
    rd_check("ovf/status", A_STATUS, 32'h0000_0128);
    check("ovf/head", {24'b0, tx_data}, 32'h60);
    cycle(A_STATUS, 32'h0000_0100, 4'b0001, 1'b0);
    rd_check("ovf/clr_wrong_lane", A_STATUS, 32'h0000_0128);
    cycle(A_STATUS, 32'h0000_0100, 4'b0010, 1'b0);
    rd_check("ovf/clr", A_STATUS, 32'h0000_0028);
    cycle(A_CONSOLE, 32'h0000_0070, 4'b0001, 1'b1);
    rd_check("ovf/push_pop_full", A_STATUS, 32'h0000_0028);
    for (int i = 0; i < 8; i++) begin
      check("ovf/drain", {24'b0, tx_data}, (i < 7) ? 32'h61 + 32'(i) : 32'h70);
      cycle(32'h0, 32'h0, 4'b0000, 1'b1);
    end
    check("ovf/txv_end", {31'b0, tx_valid}, 32'd0);

    // MTIME: count from reset, load, wrap, partial write
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_check("mtime/rst", A_MTIME, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    rd_check("mtime/n10", A_MTIME, 32'd10);
    cycle(A_MTIME, 32'hFFFF_FFFE, 4'b1111, 1'b0);
    rd_check("mtime/load", A_MTIME, 32'hFFFF_FFFE);
    check("mtime/load_err", {31'b0, bus_err}, 32'd0);
    @(posedge clk);
    #1;
    rd_check("mtime/max", A_MTIME, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    rd_check("mtime/wrap", A_MTIME, 32'h0);
    cycle(A_MTIME, 32'h1234_5678, 4'b0011, 1'b0);
    rd_check("mtime/partial", A_MTIME, 32'd1);
    check("mtime/partial_err", {31'b0, bus_err}, 32'd1);
    @(posedge clk);
    #1;
    rd_check("mtime/after_partial", A_MTIME, 32'd2);
    check("mtime/err_pulse", {31'b0, bus_err}, 32'd0);

    // Reset with bytes queued and overflow set
    cycle(32'h200, 32'h1357_9BDF, 4'b1111, 1'b0);
    for (int i = 0; i < 9; i++) cycle(A_CONSOLE, 32'h80 + 32'(i), 4'b0001, 1'b0);
    repeat (4) cycle(32'h0, 32'h0, 4'b0000, 1'b1);
    rd_check("rst_mid/pre_status", A_STATUS, 32'h0000_0104);
    reset  = 1'b1;
    daddr  = 32'h100;
    dwdata = 32'h0;
    dwe    = 4'b1111;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    dwe    = 4'b0000;
    check("rst_mid/txv", {31'b0, tx_valid}, 32'd0);
    check("rst_mid/err", {31'b0, bus_err}, 32'd0);
    rd_check("rst_mid/status", A_STATUS, 32'h0000_0040);
    rd_check("rst_mid/mtime", A_MTIME, 32'd0);
    rd_check("rst_mid/ram200", 32'h200, 32'h1357_9BDF);
    rd_check("rst_mid/ram100", 32'h100, 32'hAAEE_CCDD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dbus_responder.md
Name: dbus_responder

Overview:
- Responder end of the CPU data bus (daddr/dwdata/dwe/drdata).
- The CPU is single-cycle, so reads are combinational; writes commit on the clock edge.
- Decodes two regions: a byte-lane-writable RAM and a small MMIO window. The window holds a console transmit FIFO, drained by a valid/ready handshake, and a free-running cycle timer.
- Flags out-of-range and malformed accesses on a registered error pulse.

Parameters:
- RAM_WORDS, 4096: RAM depth in 32-bit words; power of 2; RAM base 0x0000_0000.
- FIFO_DEPTH, 8: console FIFO entries; power of 2, ≥2.
- MMIO_BASE, 32'hFFFF_0000: base of the 16-byte MMIO window.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset; clock clk
- daddr  in  32  byte address from CPU
- dwdata  in  32  write data, byte lanes already positioned by the CPU
- dwe  in  4  byte write enables; lane i = dwdata[8i+7:8i]; 0 means read
- drdata  out  32  read data, combinational from daddr
- tx_data  out  8  head byte of the console FIFO
- tx_valid  out  1  FIFO non-empty
- tx_ready  in  1  consumer accepts tx_data this cycle
- bus_err  out  1  one-cycle registered pulse on an illegal access

Behaviour:
- Decode:
  - RAM hit: daddr < RAM_WORDS*4.
  - MMIO hit: daddr[31:4] == MMIO_BASE[31:4].
  - Anything else is unmapped.
  - daddr[1:0] is ignored for decode; lanes come from dwe.
- RAM:
  - Read: drdata = mem[daddr[log2(RAM_WORDS)+1:2]], zero latency.
  - Write: on posedge, each lane with dwe[i]=1 is written. Suppressed while reset=1.
  - Contents are not cleared by reset.
  - A write followed by a read of the same word in the next cycle returns the new data.
- MMIO registers (word offsets):
  - 0x0 CONSOLE.
    - Write with dwe[0]=1 pushes dwdata[7:0].
    - Read returns {24'b0, tx_data} (peek only, no pop).
  - 0x4 MTIME.
    - Read returns the counter.
    - Write with dwe==4'b1111 loads dwdata; the next read shows dwdata, and the counter resumes incrementing the following cycle.
    - Partial write: ignored and raises bus_err.
  - 0x8 STATUS, read fields:
    - [4:0] count
    - [5] full
    - [6] empty
    - [8] overflow (sticky)
    - other bits 0
  - 0x8 STATUS write: dwe[1]=1 with dwdata[8]=1 clears overflow.
  - 0xC: reads 0; writes ignored.
- MTIME:
  - Increments by 1 every cycle that is not a load or reset.
  - Wraps 0xFFFF_FFFF → 0 silently.
- Console FIFO:
  - Push when a CONSOLE write occurs. Pop when tx_valid && tx_ready.
  - tx_valid = (count != 0), registered state with no bypass. A push into an empty FIFO shows tx_valid=1 on the next cycle.
  - tx_data = head entry, stable while tx_valid=1 and tx_ready=0.
  - Push while full and no pop: byte is dropped, overflow set, count unchanged.
  - Push while full with a simultaneous pop: both happen, count stays at FIFO_DEPTH, no overflow.
  - Push and pop in the same cycle when not full: count unchanged, order preserved.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- Unmapped access:
  - Read returns 32'h0.
  - Write is ignored.
  - bus_err is asserted for exactly one cycle after the edge at which the access was present, for unmapped access with dwe≠0 and for a partial MTIME write. Unmapped reads do not raise bus_err, because the CPU drives daddr speculatively.
- Reset (sync), applied at the edge:
  - FIFO emptied (pointers and count 0), so tx_valid=0 next cycle; in-flight bytes are discarded.
  - overflow=0, MTIME=0, bus_err=0.
  - Bus writes are blocked while reset=1.

Decomposition:
- Shared package dbus_pkg holds:
  - MMIO offset constants: CONSOLE=0x0, MTIME=0x4, STATUS=0x8.
  - STATUS bit positions: COUNT_LSB, FULL_BIT=5, EMPTY_BIT=6, OVF_BIT=8.
  - The MMIO_BASE default.
- One natural sub-module, sync_fifo:
  - Parameterised by width and depth.
  - Ports: push, din, pop, dout, count, full, empty.
  - Reset synchronously.
  - Instantiated once for the console.
- RAM, decode and MTIME stay in the top.

Test Plan:
- RAM byte lanes: write 0xAABBCCDD at 0x100 with dwe=1111, then write dwdata=0x00EE0000 with dwe=0100 → read at 0x100 returns 0xAAEECCDD; bus_err stays 0.
- Console ordering and backpressure:
  - Push 0x41, 0x42, 0x43 with tx_ready=0 → tx_valid rises the cycle after the first push, tx_data=0x41, STATUS count=3.
  - Then set tx_ready=1 for 3 cycles → bytes 0x41, 0x42, 0x43 are observed in order, and tx_valid=0 afterwards.
- Console overflow:
  - Push 9 bytes with tx_ready=0 → count=8, full=1, overflow=1, 9th byte absent.
  - Push while full with tx_ready=1 in the same cycle → count stays 8, no new overflow.
  - Write STATUS with dwdata=0x100, dwe=0010 → overflow reads 0.
- MTIME:
  - After reset, read MTIME at N cycles → N (±0 with a defined sample point).
  - Write 0xFFFF_FFFE with dwe=1111 → reads 0xFFFF_FFFE, then 0xFFFF_FFFF, then 0x0000_0000.
  - Write with dwe=0011 → value unchanged, bus_err pulses for 1 cycle.
- Unmapped access: write 0x8000_0000 with dwe=1111 → bus_err=1 for exactly one cycle, no RAM/MMIO change; read of the same address → drdata=0, bus_err=0.
- Reset mid-transfer: with 4 bytes queued and tx_ready=0, assert reset for 1 cycle → tx_valid=0, count=0, MTIME=0, overflow=0; a RAM word written beforehand still reads back unchanged.
